rom_loader: RTL

- Upstream feeder for the ROM backdoor bus (32-bit data, 32-bit address, cyc/strobe/we, ack).
- Receives a framed program image over a UART 8N1 serial line and packs the bytes into 32-bit words.
- Issues one classic Wishbone write per word, so ROM contents can be loaded without resynthesis.
- Reports busy/done/error status to the system top level.

---
 rtl/rom_loader.sv | 295 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : rom_loader
// Purpose  : Receives a framed program image over UART 8N1 (0x55, L, 4*L data
//            bytes, checksum). It packs the bytes into 32-bit words and writes
//            each word over a classic Wishbone bus into ROM backdoor storage.
// Options  : ROM_LOADER_READBACK_EN - read each word back after its write and
//            flag a mismatch as a checksum/readback error.
// Revision : 1.0 - initial release
// ============================================================================
module rom_loader #(
    parameter int          CLKS_PER_BIT = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter logic [31:0] ADDR_STRIDE  = 32'h1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    output logic [31:0] data_o,
    output logic [31:0] addr_o,
    output logic        cyc_o,
    output logic        strobe_o,
    output logic        we_o,
    input  logic [31:0] data_i,
    input  logic        ack_i,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code
);

    localparam int                 c_CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_M1 = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0]         c_SYNC    = 8'h55;

    localparam logic [1:0] c_U_IDLE  = 2'd0;
    localparam logic [1:0] c_U_START = 2'd1;
    localparam logic [1:0] c_U_DATA  = 2'd2;
    localparam logic [1:0] c_U_STOP  = 2'd3;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LEN   = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_WRITE = 3'd3;
    localparam logic [2:0] c_ST_CSUM  = 3'd4;
`ifdef ROM_LOADER_READBACK_EN
    localparam logic [2:0] c_ST_READ  = 3'd5;
    localparam logic [2:0] c_ST_LAST  = c_ST_READ;
`else
    localparam logic [2:0] c_ST_LAST  = c_ST_WRITE;
`endif

    localparam logic [1:0] c_ERR_FRAME   = 2'd1;
    localparam logic [1:0] c_ERR_OVERRUN = 2'd2;
    localparam logic [1:0] c_ERR_CSUM    = 2'd3;

    logic               r_rx_meta, r_rx_sync, r_rx_prev;
    logic [1:0]         r_u_state;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_byte_done, r_frame_err;
    logic [7:0]         r_hold_data;
    logic               r_hold_valid;
    logic [2:0]         r_state, w_state_next, w_after_word;
    logic [31:0]        r_word, r_addr;
    logic [1:0]         r_byte_idx;
    logic [7:0]         r_sum;
    logic [8:0]         r_words_left;
    logic               r_cyc, r_we;
    logic               r_busy, r_done, r_error;
    logic [1:0]         r_err_code;
    logic               w_in_bus, w_consume, w_overrun, w_ack, w_final_ack;
    logic               w_rb_err, w_abort;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // UART receiver: validate start bit at half-bit, then sample mid-bit LSB first
    always_ff @(posedge clock) begin
        if (reset) begin
            r_u_state   <= c_U_IDLE;
            r_bit_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_byte_done <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_byte_done <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_u_state)
                c_U_IDLE: begin
                    if (r_rx_prev && !r_rx_sync) begin
                        r_u_state <= c_U_START;
                        r_bit_cnt <= '0;
                    end
                end
                c_U_START: begin
                    if (r_bit_cnt == c_HALF_M1) begin
                        r_bit_cnt <= '0;
                        r_bit_idx <= '0;
                        r_u_state <= r_rx_sync ? c_U_IDLE : c_U_DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                c_U_DATA: begin
                    if (r_bit_cnt == c_FULL_M1) begin
                        r_bit_cnt <= '0;
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_u_state <= c_U_STOP;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_bit_cnt == c_FULL_M1) begin
                        r_bit_cnt   <= '0;
                        r_byte_done <= r_rx_sync;
                        r_frame_err <= !r_rx_sync;
                        r_u_state   <= c_U_IDLE;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // The FSM leaves bytes in the holding register only while a bus cycle is pending
`ifdef ROM_LOADER_READBACK_EN
    assign w_in_bus = (r_state == c_ST_WRITE) || (r_state == c_ST_READ);
    assign w_rb_err = w_final_ack && (data_i != r_word);
`else
    logic w_unused_data_i;
    assign w_unused_data_i = ^data_i;
    assign w_in_bus = (r_state == c_ST_WRITE);
    assign w_rb_err = 1'b0;
`endif

    assign w_consume    = r_hold_valid && !w_in_bus;
    assign w_overrun    = r_byte_done && r_hold_valid && !w_consume;
    assign w_ack        = r_cyc && ack_i;
    assign w_final_ack  = w_ack && (r_state == c_ST_LAST);
    assign w_abort      = r_frame_err || w_overrun || w_rb_err;
    assign w_after_word = (r_words_left == 9'd1) ? c_ST_CSUM : c_ST_DATA;

    // One-byte holding register; flushed on abort so stale bytes cannot start a frame
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
        end else if (w_abort) begin
            r_hold_valid <= 1'b0;
        end else if (r_byte_done) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= r_shift;
        end else if (w_consume) begin
            r_hold_valid <= 1'b0;
        end
    end

    // Frame FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Frame FSM next-state logic; any error returns to IDLE
    always_comb begin
        w_state_next = r_state;
        if (w_abort) begin
            w_state_next = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE:  if (w_consume && r_hold_data == c_SYNC) w_state_next = c_ST_LEN;
                c_ST_LEN:   if (w_consume) w_state_next = c_ST_DATA;
                c_ST_DATA:  if (w_consume && r_byte_idx == 2'd3) w_state_next = c_ST_WRITE;
`ifdef ROM_LOADER_READBACK_EN
                c_ST_WRITE: if (w_ack) w_state_next = c_ST_READ;
                c_ST_READ:  if (w_ack) w_state_next = w_after_word;
`else
                c_ST_WRITE: if (w_ack) w_state_next = w_after_word;
`endif
                c_ST_CSUM:  if (w_consume) w_state_next = c_ST_IDLE;
                default:    w_state_next = c_ST_IDLE;
            endcase
        end
    end

    // Datapath, bus handshake and sticky status; an aborted bus cycle still waits for ack
    always_ff @(posedge clock) begin
        if (reset) begin
            r_word       <= '0;
            r_addr       <= BASE_ADDR;
            r_byte_idx   <= '0;
            r_sum        <= '0;
            r_words_left <= '0;
            r_cyc        <= 1'b0;
            r_we         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_err_code   <= '0;
        end else begin
            if (w_ack) begin
                r_cyc <= 1'b0;
                r_we  <= 1'b0;
            end
`ifdef ROM_LOADER_READBACK_EN
            if (r_state == c_ST_READ && !r_cyc && !w_abort) begin
                r_cyc <= 1'b1;
                r_we  <= 1'b0;
            end
`endif
            if (w_final_ack) begin
                r_addr       <= r_addr + ADDR_STRIDE;
                r_words_left <= r_words_left - 1'b1;
            end
            if (w_consume && !w_abort) begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (r_hold_data == c_SYNC) begin
                            r_busy     <= 1'b1;
                            r_done     <= 1'b0;
                            r_error    <= 1'b0;
                            r_err_code <= '0;
                        end
                    end
                    c_ST_LEN: begin
                        r_words_left <= (r_hold_data == 8'd0) ? 9'd256 : {1'b0, r_hold_data};
                        r_addr       <= BASE_ADDR;
                        r_byte_idx   <= '0;
                        r_sum        <= '0;
                    end
                    c_ST_DATA: begin
                        r_word[{r_byte_idx, 3'b000} +: 8] <= r_hold_data;
                        r_sum      <= r_sum + r_hold_data;
                        r_byte_idx <= r_byte_idx + 1'b1;
                        if (r_byte_idx == 2'd3) begin
                            r_cyc <= 1'b1;
                            r_we  <= 1'b1;
                        end
                    end
                    c_ST_CSUM: begin
                        r_busy <= 1'b0;
                        if (r_hold_data == r_sum) begin
                            r_done <= 1'b1;
                        end else begin
                            r_error    <= 1'b1;
                            r_err_code <= c_ERR_CSUM;
                        end
                    end
                    default: ;
                endcase
            end
            if (w_abort) begin
                r_busy     <= 1'b0;
                r_done     <= 1'b0;
                r_error    <= 1'b1;
                r_err_code <= r_frame_err ? c_ERR_FRAME :
                              (w_overrun ? c_ERR_OVERRUN : c_ERR_CSUM);
            end
        end
    end

    assign data_o   = r_word;
    assign addr_o   = r_addr;
    assign cyc_o    = r_cyc;
    assign strobe_o = r_cyc;
    assign we_o     = r_we;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;
    assign err_code = r_err_code;

endmodule
`default_nettype wire
